mem_access_unit: RTL and testbench

- Initiator side of the word-addressed data-memory port. The CPU memory stage issues byte, halfword and word loads and stores to it.
- It drives the memory's rd/wr/addr/wdata and consumes rdata. Sub-word stores use read-modify-write because the memory writes whole words only.
- It sign- or zero-extends sub-word loads and flags misaligned or out-of-range accesses.
- It sits between the pipeline MEM stage and the data memory, and stalls the pipeline through req_ready.

---
 rtl/mem_access_unit.sv | 171 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory initiator: sub-word loads with extension, sub-word stores via read-modify-write.
// Latency 1 (error), 2 (load/SW) or 3 (SH/SB) cycles from accept; req_ready is low whenever the FSM is busy.
module mem_access_unit #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        misaligned;
    logic        req_err;
    logic        req_is_load;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_ext;
    logic [31:0] merged_nxt;

    always_comb begin
        misaligned = 1'b0;
        case (req_op)
            OP_LW, OP_SW:         misaligned = |req_addr[1:0];
            OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
            default:              misaligned = 1'b0;
        endcase
    end

    assign req_err     = misaligned || (req_addr >= ADDR_LIMIT);
    assign req_is_load = (req_op <= OP_LBU);

    // Little-endian lane selection from the latched byte offset.
    assign lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_rdata;
        case (op_q)
            OP_LH:   load_ext = {{16{lane_half[15]}}, lane_half};
            OP_LHU:  load_ext = {16'h0000, lane_half};
            OP_LB:   load_ext = {{24{lane_byte[7]}}, lane_byte};
            OP_LBU:  load_ext = {24'h000000, lane_byte};
            default: load_ext = mem_rdata;
        endcase
    end

    // merged_q holds the raw store data until the read half of an RMW overwrites it.
    always_comb begin
        merged_nxt = mem_rdata;
        if (op_q == OP_SB) begin
            merged_nxt[{addr_q[1:0], 3'b000} +: 8] = merged_q[7:0];
        end else begin
            merged_nxt[{addr_q[1], 4'b0000} +: 16] = merged_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = 32'h0;
        mem_addr   = {addr_q[31:2], 2'b00};
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_addr  = 32'h0;
                if (req_valid) begin
                    if (req_err)          state_nxt = RESP;
                    else if (req_is_load) state_nxt = RD;
                    else if (req_op == OP_SW) state_nxt = WR;
                    else                  state_nxt = RMW_RD;
                end
            end
            RD: begin
                mem_rd    = 1'b1;
                state_nxt = RESP;
            end
            RMW_RD: begin
                mem_rd    = 1'b1;
                state_nxt = WR;
            end
            WR: begin
                mem_wr    = 1'b1;
                mem_wdata = merged_q;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q     <= 3'b000;
            addr_q   <= 32'h0;
            merged_q <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr;
                        merged_q <= req_wdata;
                        err_q    <= req_err;
                        if (req_err) rdata_q <= 32'h0;
                    end
                end
                RD:      rdata_q  <= load_ext;
                RMW_RD:  merged_q <= merged_nxt;
                WR:      rdata_q  <= 32'h0;
                default: ;
            endcase
        end
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit against a small word-array memory model.
module tb_mem_access_unit;

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
    localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    logic        poke_we = 1'b0;
    logic [7:0]  poke_idx = 8'h0;
    logic [31:0] poke_dat = 32'h0;

    int errors = 0;
    int checks = 0;

    int          ob_lat, ob_rd, ob_wr, ob_rd_cyc, ob_wr_cyc, ob_both;
    logic [31:0] ob_rdata, ob_maddr, ob_wdata;
    logic        ob_err, ob_ready, ob_resp_after;

    mem_access_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (poke_we) mem[poke_idx] <= poke_dat;
        else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_we = 1'b1; poke_idx = a[9:2]; poke_dat = d;
        @(negedge clk);
        poke_we = 1'b0;
    endtask

    // Issues one request and records what the DUT does until its response (bounded).
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
        ob_ready = req_ready;
        @(posedge clk);
        ob_lat = -1; ob_rd = 0; ob_wr = 0; ob_rd_cyc = -1; ob_wr_cyc = -1; ob_both = 0;
        ob_rdata = 32'hx; ob_err = 1'bx; ob_maddr = 32'hx; ob_wdata = 32'hx;
        for (int c = 1; c <= 8 && ob_lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0; req_op = SB; req_addr = 32'h0000_0004; req_wdata = 32'h5A5A_5A5A;
            end
            if (mem_rd) begin ob_rd++; ob_rd_cyc = c; ob_maddr = mem_addr; end
            if (mem_wr) begin ob_wr++; ob_wr_cyc = c; ob_wdata = mem_wdata; ob_maddr = mem_addr; end
            if (mem_rd && mem_wr) ob_both = 1;
            if (resp_valid) begin ob_lat = c; ob_rdata = resp_rdata; ob_err = resp_err; end
        end
        @(negedge clk);
        ob_resp_after = resp_valid;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b exp 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b exp 0", resp_err); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", resp_rdata); end
        checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL reset_mem_rdwr got %b exp 00", {mem_rd, mem_wr}); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h exp 0", mem_wdata); end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_sb;
        int wr_seen = 0;
        int rv_seen = 0;
        poke(32'h30, 32'h1122_3344);
        @(negedge clk);
        req_valid = 1'b1; req_op = SB; req_addr = 32'h31; req_wdata = 32'h0000_00AA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL midsb_rmw_rd got %b exp 1", mem_rd); end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midsb_ready got %b exp 1", req_ready); end
        for (int i = 0; i < 5; i++) begin
            if (mem_wr) wr_seen++;
            if (resp_valid) rv_seen++;
            @(negedge clk);
        end
        checks++; if (wr_seen !== 0) begin errors++; $display("FAIL midsb_mem_wr got %0d exp 0", wr_seen); end
        checks++; if (rv_seen !== 0) begin errors++; $display("FAIL midsb_resp_valid got %0d exp 0", rv_seen); end
        checks++; if (mem[12] !== 32'h1122_3344) begin errors++; $display("FAIL midsb_mem_word got %h exp 11223344", mem[12]); end
    endtask

    task automatic test_lw;
        poke(32'h10, 32'h8081_7F01);
        send(LW, 32'h10, 32'h0);
        checks++; if (ob_ready !== 1'b1) begin errors++; $display("FAIL lw_ready got %b exp 1", ob_ready); end
        checks++; if (ob_rd_cyc !== 1) begin errors++; $display("FAIL lw_rd_cycle got %0d exp 1", ob_rd_cyc); end
        checks++; if (ob_maddr !== 32'h10) begin errors++; $display("FAIL lw_mem_addr got %h exp 10", ob_maddr); end
        checks++; if (ob_lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", ob_lat); end
        checks++; if (ob_rdata !== 32'h8081_7F01) begin errors++; $display("FAIL lw_rdata got %h exp 80817f01", ob_rdata); end
        checks++; if (ob_err !== 1'b0) begin errors++; $display("FAIL lw_err got %b exp 0", ob_err); end
        checks++; if (ob_resp_after !== 1'b0) begin errors++; $display("FAIL lw_resp_one_cycle got %b exp 0", ob_resp_after); end
    endtask

    task automatic test_subword_loads;
        logic [2:0]  ops [7] = '{LB, LBU, LH, LHU, LB, LH, LBU};
        logic [31:0] adr [7] = '{32'h12, 32'h12, 32'h12, 32'h10, 32'h13, 32'h10, 32'h11};
        logic [31:0] exp [7] = '{32'hFFFF_FF81, 32'h0000_0081, 32'hFFFF_8081, 32'h0000_7F01,
                                 32'hFFFF_FF80, 32'h0000_7F01, 32'h0000_007F};
        for (int i = 0; i < 7; i++) begin
            send(ops[i], adr[i], 32'h0);
            checks++; if (ob_rdata !== exp[i]) begin errors++; $display("FAIL subload%0d_rdata got %h exp %h", i, ob_rdata, exp[i]); end
            checks++; if (ob_lat !== 2 || ob_err !== 1'b0 || ob_wr !== 0) begin
                errors++; $display("FAIL subload%0d_timing lat=%0d err=%b wr=%0d exp lat=2 err=0 wr=0", i, ob_lat, ob_err, ob_wr);
            end
        end
    endtask

    task automatic test_stores;
        poke(32'h20, 32'h1122_3344);
        send(SB, 32'h21, 32'h0000_00AA);
        checks++; if (ob_rd_cyc !== 1 || ob_wr_cyc !== 2 || ob_lat !== 3) begin
            errors++; $display("FAIL sb_timing rd=%0d wr=%0d lat=%0d exp 1 2 3", ob_rd_cyc, ob_wr_cyc, ob_lat);
        end
        checks++; if (ob_wdata !== 32'h1122_AA44) begin errors++; $display("FAIL sb_wdata got %h exp 1122aa44", ob_wdata); end
        checks++; if (ob_rdata !== 32'h0 || ob_err !== 1'b0) begin errors++; $display("FAIL sb_resp rdata=%h err=%b exp 0 0", ob_rdata, ob_err); end
        checks++; if (mem[8] !== 32'h1122_AA44) begin errors++; $display("FAIL sb_mem got %h exp 1122aa44", mem[8]); end
        checks++; if (ob_both !== 0) begin errors++; $display("FAIL sb_rd_and_wr got %0d exp 0", ob_both); end
        poke(32'h20, 32'h1122_3344);
        send(SH, 32'h22, 32'h0000_BEEF);
        checks++; if (ob_wdata !== 32'hBEEF_3344 || ob_lat !== 3) begin
            errors++; $display("FAIL sh_wdata got %h lat %0d exp beef3344 lat 3", ob_wdata, ob_lat);
        end
        send(SB, 32'h23, 32'h0000_0012);
        checks++; if (mem[8] !== 32'h12EF_3344) begin errors++; $display("FAIL sb_lane3_mem got %h exp 12ef3344", mem[8]); end
        send(LW, 32'h10, 32'h0);
        send(SW, 32'h24, 32'hDEAD_BEEF);
        checks++; if (ob_wr_cyc !== 1 || ob_rd !== 0 || ob_lat !== 2) begin
            errors++; $display("FAIL sw_timing wr=%0d rd=%0d lat=%0d exp 1 0 2", ob_wr_cyc, ob_rd, ob_lat);
        end
        checks++; if (ob_wdata !== 32'hDEAD_BEEF || ob_maddr !== 32'h24) begin
            errors++; $display("FAIL sw_bus wdata=%h addr=%h exp deadbeef 24", ob_wdata, ob_maddr);
        end
        checks++; if (ob_rdata !== 32'h0) begin errors++; $display("FAIL sw_rdata got %h exp 0", ob_rdata); end
    endtask

    task automatic test_errors;
        logic [2:0]  ops [5] = '{LW, SH, SW, LB, LHU};
        logic [31:0] adr [5] = '{32'h13, 32'h21, 32'h400, 32'h400, 32'h3FF};
        for (int i = 0; i < 5; i++) begin
            send(LW, 32'h10, 32'h0);
            send(ops[i], adr[i], 32'hFFFF_FFFF);
            checks++; if (ob_lat !== 1 || ob_err !== 1'b1) begin
                errors++; $display("FAIL err%0d_resp lat=%0d err=%b exp lat=1 err=1", i, ob_lat, ob_err);
            end
            checks++; if (ob_rdata !== 32'h0) begin errors++; $display("FAIL err%0d_rdata got %h exp 0", i, ob_rdata); end
            checks++; if (ob_rd !== 0 || ob_wr !== 0) begin errors++; $display("FAIL err%0d_mem rd=%0d wr=%0d exp 0 0", i, ob_rd, ob_wr); end
        end
        send(LB, 32'h3FF, 32'h0);
        checks++; if (ob_lat !== 2 || ob_err !== 1'b0 || ob_maddr !== 32'h3FC) begin
            errors++; $display("FAIL lb_3ff lat=%0d err=%b addr=%h exp 2 0 3fc", ob_lat, ob_err, ob_maddr);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] dat [4] = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004};
        int idx = 0, acc = 0, wr = 0, rd = 0, viol = 0, bad_gap = 0, last_acc = -10;
        logic acc_last = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = SW; req_addr = 32'h40; req_wdata = dat[0];
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (acc_last) begin
                idx++;
                if (idx < 4) begin req_addr = 32'h40 + 32'(4 * idx); req_wdata = dat[idx]; end
                else req_valid = 1'b0;
            end
            acc_last = 1'b0;
            if (mem_wr) wr++;
            if (mem_rd) rd++;
            if (req_ready && (mem_wr || resp_valid)) viol++;
            if (!req_ready && !mem_wr && !resp_valid) viol++;
            if (req_valid && req_ready) begin
                if (acc > 0 && cyc - last_acc != 3) bad_gap++;
                acc++; last_acc = cyc; acc_last = 1'b1;
            end
        end
        checks++; if (acc !== 4) begin errors++; $display("FAIL b2b_accepts got %0d exp 4", acc); end
        checks++; if (wr !== 4 || rd !== 0) begin errors++; $display("FAIL b2b_mem wr=%0d rd=%0d exp 4 0", wr, rd); end
        checks++; if (viol !== 0) begin errors++; $display("FAIL b2b_ready got %0d violations exp 0", viol); end
        checks++; if (bad_gap !== 0) begin errors++; $display("FAIL b2b_spacing got %0d bad gaps exp 0", bad_gap); end
        checks++; if (mem[16] !== dat[0] || mem[19] !== dat[3]) begin
            errors++; $display("FAIL b2b_mem_data got %h %h exp %h %h", mem[16], mem[19], dat[0], dat[3]);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_sb();
        test_lw();
        test_subword_loads();
        test_stores();
        test_errors();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
